// File: rtl/ccff_loader.sv
// ---------------------------------------------------------------------------
// ccff_loader
// Loads the configuration chain of one tile (connection block plus its I/O
// grid). The I/O stays isolated for ISO_CYCLES before the first shift and
// after the last shift. The bitstream streams into ccff_head over a
// valid/ready handshake. Isolation is released only after a successful load.
//
// Ports
//   prog_clk      : clock; all logic runs on its rising edge
//   prog_reset    : synchronous, active-high reset
//   start         : single-cycle load request (ignored while busy)
//   abort         : cancels a load in progress
//   bs_valid      : bitstream bit available
//   bs_data       : bitstream bit
//   bs_ready      : loader accepts a bit this cycle
//   ccff_head     : serial data to the chain head
//   ccff_shift_en : chain clock enable, one pulse per accepted bit
//   isol_n        : I/O isolation, active-low
//   busy          : load in progress
//   done          : sticky, last load completed
//   err           : sticky, last load failed
//   err_code      : failure cause, 01 timeout, 10 abort
// ---------------------------------------------------------------------------
module ccff_loader #(
    parameter int unsigned CHAIN_LEN  = 64,
    parameter int unsigned ISO_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       prog_clk,
    input  logic       prog_reset,
    input  logic       start,
    input  logic       abort,
    input  logic       bs_valid,
    input  logic       bs_data,
    output logic       bs_ready,
    output logic       ccff_head,
    output logic       ccff_shift_en,
    output logic       isol_n,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned BIT_W   = $clog2(CHAIN_LEN + 1);
    localparam int unsigned ISO_W   = (ISO_CYCLES > 0) ? $clog2(ISO_CYCLES + 1) : 1;
    localparam int unsigned STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [BIT_W-1:0]   BIT_LOAD   = BIT_W'(CHAIN_LEN);
    localparam logic [ISO_W-1:0]   ISO_LOAD   = ISO_W'(ISO_CYCLES);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_LAST = (TIMEOUT > 0) ? STALL_W'(TIMEOUT - 1) : '0;

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ABORT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_ISO,
        S_SHIFT,
        S_POST_ISO,
        S_ERR
    } state_t;

    state_t               r_state;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [ISO_W-1:0]     r_iso_cnt;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic                 r_bs_ready;
    logic                 r_head;
    logic                 r_shift_en;
    logic                 r_isol_n;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [1:0]           r_err_code;

    logic                 w_active;
    logic                 w_abort;
    logic                 w_xfer;
    logic                 w_stall_hit;

    // Abort only matters while a load is running; it also suppresses any transfer.
    assign w_active    = (r_state == S_PRE_ISO) || (r_state == S_SHIFT) || (r_state == S_POST_ISO);
    assign w_abort     = abort && w_active;
    assign w_xfer      = r_bs_ready && bs_valid;
    // This stall cycle is the one that brings the stall count up to TIMEOUT.
    assign w_stall_hit = !bs_valid && (r_stall_cnt >= STALL_LAST);

    // Load sequencer with registered outputs.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_iso_cnt   <= '0;
            r_stall_cnt <= '0;
            r_bs_ready  <= 1'b0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_isol_n    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_shift_en <= 1'b0;
            if (w_abort) begin
                r_state    <= S_ERR;
                r_err      <= 1'b1;
                r_err_code <= ERR_ABORT;
                r_busy     <= 1'b0;
                r_bs_ready <= 1'b0;
                r_isol_n   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_ERR: begin
                        if (start) begin
                            r_state     <= S_PRE_ISO;
                            r_busy      <= 1'b1;
                            r_isol_n    <= 1'b0;
                            r_done      <= 1'b0;
                            r_err       <= 1'b0;
                            r_err_code  <= 2'b00;
                            r_bit_cnt   <= BIT_LOAD;
                            r_iso_cnt   <= ISO_LOAD;
                            r_stall_cnt <= '0;
                        end
                    end
                    S_PRE_ISO: begin
                        if (r_iso_cnt != '0) begin
                            r_iso_cnt <= r_iso_cnt - ISO_W'(1);
                        end
                        if (r_iso_cnt <= ISO_W'(1)) begin
                            r_state    <= S_SHIFT;
                            r_bs_ready <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (w_xfer) begin
                            r_head      <= bs_data;
                            r_shift_en  <= 1'b1;
                            r_bit_cnt   <= r_bit_cnt - BIT_W'(1);
                            r_stall_cnt <= '0;
                            // Last bit of the chain: close the handshake and guard the exit.
                            if (r_bit_cnt == BIT_W'(1)) begin
                                r_state    <= S_POST_ISO;
                                r_iso_cnt  <= ISO_LOAD;
                                r_bs_ready <= 1'b0;
                            end
                        end else if (w_stall_hit) begin
                            r_stall_cnt <= STALL_MAX;
                            r_state     <= S_ERR;
                            r_err       <= 1'b1;
                            r_err_code  <= ERR_TIMEOUT;
                            r_busy      <= 1'b0;
                            r_bs_ready  <= 1'b0;
                        end else if (!bs_valid) begin
                            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                        end
                    end
                    S_POST_ISO: begin
                        if (r_iso_cnt != '0) begin
                            r_iso_cnt <= r_iso_cnt - ISO_W'(1);
                        end
                        if (r_iso_cnt <= ISO_W'(1)) begin
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_isol_n <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bs_ready      = r_bs_ready;
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign isol_n        = r_isol_n;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign err_code      = r_err_code;

endmodule

// File: tb/tb_ccff_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_loader
// Directed bench for ccff_loader (CHAIN_LEN=8, ISO_CYCLES=2, TIMEOUT=4).
// A behavioural model tracks the load phase, remaining guard cycles,
// remaining bits and the current stall run; a compare process checks every
// DUT output against it on each falling edge. Literal checks pin the
// model to hand-computed cycle positions and bit sequences.
// ---------------------------------------------------------------------------
module tb_ccff_loader;

    localparam int unsigned CL  = 8;
    localparam int unsigned ISO = 2;
    localparam int unsigned TO  = 4;

    localparam int P_IDLE  = 0;
    localparam int P_PRE   = 1;
    localparam int P_SHIFT = 2;
    localparam int P_POST  = 3;
    localparam int P_ERR   = 4;

    logic       prog_clk = 1'b0;
    logic       prog_reset;
    logic       start;
    logic       abort;
    logic       bs_valid;
    logic       bs_data;
    logic       bs_ready;
    logic       ccff_head;
    logic       ccff_shift_en;
    logic       isol_n;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    ccff_loader #(
        .CHAIN_LEN (CL),
        .ISO_CYCLES(ISO),
        .TIMEOUT   (TO)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .start        (start),
        .abort        (abort),
        .bs_valid     (bs_valid),
        .bs_data      (bs_data),
        .bs_ready     (bs_ready),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .isol_n       (isol_n),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code)
    );

    always #5 prog_clk = ~prog_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: dut=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_phase     = P_IDLE;
    int         m_guard     = 0;
    int         m_bits_left = 0;
    int         m_stall     = 0;
    logic       m_head      = 1'b0;
    logic       m_shift     = 1'b0;
    logic       m_done      = 1'b0;
    logic       m_err       = 1'b0;
    logic [1:0] m_code      = 2'b00;

    task automatic m_fail(input logic [1:0] code);
        m_phase = P_ERR;
        m_err   = 1'b1;
        m_code  = code;
    endtask

    always @(posedge prog_clk) begin
        m_shift = 1'b0;
        if (prog_reset) begin
            m_phase     = P_IDLE;
            m_guard     = 0;
            m_bits_left = 0;
            m_stall     = 0;
            m_head      = 1'b0;
            m_done      = 1'b0;
            m_err       = 1'b0;
            m_code      = 2'b00;
        end else if (abort && (m_phase == P_PRE || m_phase == P_SHIFT || m_phase == P_POST)) begin
            m_fail(2'b10);
        end else begin
            case (m_phase)
                P_IDLE, P_ERR: begin
                    if (start) begin
                        m_phase     = P_PRE;
                        m_guard     = ISO;
                        m_bits_left = CL;
                        m_stall     = 0;
                        m_done      = 1'b0;
                        m_err       = 1'b0;
                        m_code      = 2'b00;
                    end
                end
                P_PRE: begin
                    m_guard--;
                    if (m_guard <= 0) m_phase = P_SHIFT;
                end
                P_SHIFT: begin
                    if (bs_valid) begin
                        m_head  = bs_data;
                        m_shift = 1'b1;
                        m_bits_left--;
                        m_stall = 0;
                        if (m_bits_left == 0) begin
                            m_phase = P_POST;
                            m_guard = ISO;
                        end
                    end else begin
                        m_stall++;
                        if (m_stall >= TO) m_fail(2'b01);
                    end
                end
                P_POST: begin
                    m_guard--;
                    if (m_guard <= 0) begin
                        m_phase = P_IDLE;
                        m_done  = 1'b1;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    function automatic logic [9:0] model_outs();
        logic e_ready, e_isol, e_busy;
        e_ready = (m_phase == P_SHIFT) && (m_bits_left > 0);
        e_isol  = (m_phase == P_IDLE) && m_done;
        e_busy  = (m_phase == P_PRE) || (m_phase == P_SHIFT) || (m_phase == P_POST);
        return {e_ready, m_head, m_shift, e_isol, e_busy, m_done, m_err, m_code};
    endfunction

    function automatic logic [9:0] dut_outs();
        return {bs_ready, ccff_head, ccff_shift_en, isol_n, busy, done, err, err_code};
    endfunction

    // ---------------- compare process ----------------
    logic       cmp_en     = 1'b0;
    int         dut_shifts = 0;
    logic [7:0] dut_seq    = 8'h00;

    always @(negedge prog_clk) begin
        if (cmp_en) begin
            check("cycle_outputs", 32'(dut_outs()), 32'(model_outs()));
            if (ccff_shift_en === 1'b1) begin
                dut_shifts++;
                dut_seq = {dut_seq[6:0], ccff_head};
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] pat      = 8'b10110010;
    logic       pat_on   = 1'b0;

    // Advance one cycle; present the next pattern bit (MSB first).
    task automatic tick();
        @(posedge prog_clk);
        #1;
        if (pat_on) bs_data = (m_bits_left > 0) ? pat[3'(m_bits_left - 1)] : 1'b0;
    endtask

    task automatic clr_obs();
        dut_shifts = 0;
        dut_seq    = 8'h00;
    endtask

    // Start a load with bs_valid held high and check done lands at cycle 13.
    task automatic full_load(input string tag);
        clr_obs();
        start = 1'b1;
        bs_valid = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        @(negedge prog_clk);
        check({tag, "_done_c12"}, 32'(done), 32'd0);
        tick();
        @(negedge prog_clk);
        check({tag, "_done_c13"}, 32'(done), 32'd1);
        check({tag, "_isol_c13"}, 32'(isol_n), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_shifts"}, 32'(dut_shifts), 32'd8);
        check({tag, "_seq"}, 32'(dut_seq), 32'hB2);
    endtask

    initial begin
        prog_reset = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        bs_valid   = 1'b0;
        bs_data    = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        @(negedge prog_clk);
        check("reset_outputs", 32'(dut_outs()), 32'd0);
        pat_on = 1'b1;

        // Nominal load; start on the cycle reset deasserts.
        prog_reset = 1'b0;
        full_load("nominal");

        // Abort while idle is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge prog_clk);
        check("idle_abort_done", 32'(done), 32'd1);
        check("idle_abort_err", 32'(err), 32'd0);

        // Backpressure with a start request while busy.
        begin
            logic seen;
            seen = 1'b0;
            clr_obs();
            start = 1'b1;
            bs_valid = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < 60 && !seen; i++) begin
                bs_valid = ~bs_valid;
                start = (i == 4);
                tick();
                start = 1'b0;
                @(negedge prog_clk);
                seen = (done === 1'b1);
            end
            check("bp_done_seen", 32'(seen), 32'd1);
            check("bp_shifts", 32'(dut_shifts), 32'd8);
            check("bp_seq", 32'(dut_seq), 32'hB2);
            check("bp_err", 32'(err), 32'd0);
        end

        // Timeout after the third bit.
        clr_obs();
        start = 1'b1;
        bs_valid = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        bs_valid = 1'b0;
        repeat (3) tick();
        @(negedge prog_clk);
        check("to_no_err_c9", 32'(err), 32'd0);
        check("to_busy_c9", 32'(busy), 32'd1);
        tick();
        @(negedge prog_clk);
        check("to_err", 32'(err), 32'd1);
        check("to_code", 32'(err_code), 32'd1);
        check("to_isol", 32'(isol_n), 32'd0);
        check("to_ready", 32'(bs_ready), 32'd0);
        check("to_shifts", 32'(dut_shifts), 32'd3);

        // Abort on the same cycle the stall count reaches the limit.
        start = 1'b1;
        bs_valid = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        bs_valid = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge prog_clk);
        check("abto_err", 32'(err), 32'd1);
        check("abto_code", 32'(err_code), 32'd2);
        full_load("after_abort");
        check("after_abort_code", 32'(err_code), 32'd0);

        // Abort during the leading guard.
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge prog_clk);
        check("pre_abort_code", 32'(err_code), 32'd2);
        check("pre_abort_busy", 32'(busy), 32'd0);

        // Reset in the middle of shifting, then reload.
        start = 1'b1;
        bs_valid = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        prog_reset = 1'b1;
        tick();
        @(negedge prog_clk);
        check("midrst_outputs", 32'(dut_outs()), 32'd0);
        prog_reset = 1'b0;
        full_load("after_reset");

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
